// File: rtl/line_buf_ctrl_pkg.sv
// Shared definitions for the line-buffer controller: FSM encoding, width helpers
// and default geometry.
package line_buf_ctrl_pkg;

    localparam int DEF_LINE_W  = 1280;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_NUM_BUF = 3;
    localparam int DEF_ROWS    = 1024;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cw(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/lb_wrap_counter.sv
// Modulo-MOD counter with synchronous clear and a wrap flag; clear and
// enable together yield the first step of a fresh count.
module lb_wrap_counter
    import line_buf_ctrl_pkg::*;
#(
    parameter  int MOD = 4,
    localparam int W   = cw(MOD)
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : count;
        wrap = en && (base == W'(MOD - 1));
    end

    always_ff @(posedge clk) begin
        if (!aclr_n)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : base + 1'b1;
        else
            count <= base;
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Rotating line-buffer controller: writes each line into one RAM of a ring
// while reading the other NUM_BUF-1 once enough lines of the frame are stored.
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter  int LINE_W  = DEF_LINE_W,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int NUM_BUF = DEF_NUM_BUF,
    parameter  int ROWS    = DEF_ROWS,
    localparam int SEL_W   = cw(NUM_BUF)
) (
    input  logic               clk,
    input  logic               aclr_n,
    input  logic               data_valid,
    input  logic               sof,
    output logic [NUM_BUF-1:0] wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [NUM_BUF-1:0] rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [SEL_W-1:0]   wr_sel,
    output logic [SEL_W-1:0]   old_sel,
    output logic               rd_valid,
    output logic               row_end,
    output logic               frame_end
);

    localparam int CW = cw(LINE_W);
    localparam int RW = cw(ROWS);
    // A frame shorter than the fill depth never reaches STREAM.
    localparam bit FILL_OK = (NUM_BUF - 2) < ROWS;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               col_wrap, row_wrap, sel_wrap;
    logic [NUM_BUF-1:0] sel_oh;
    lb_state_t          state, state_d;

    lb_wrap_counter #(.MOD(LINE_W)) u_col (
        .clk(clk), .aclr_n(aclr_n), .clr(sof), .en(data_valid),
        .count(col), .wrap(col_wrap)
    );

    lb_wrap_counter #(.MOD(ROWS)) u_row (
        .clk(clk), .aclr_n(aclr_n), .clr(sof), .en(col_wrap),
        .count(row), .wrap(row_wrap)
    );

    lb_wrap_counter #(.MOD(NUM_BUF)) u_sel (
        .clk(clk), .aclr_n(aclr_n), .clr(1'b0), .en(col_wrap),
        .count(wr_sel), .wrap(sel_wrap)
    );

    assign sel_oh   = NUM_BUF'(1) << wr_sel;
    assign rd_valid = (state == STREAM);

    // Within FILL the row counter doubles as the completed-line fill count.
    always_comb begin
        state_d = state;
        if (sof || row_wrap)
            state_d = FILL;
        else if (state == FILL && col_wrap && FILL_OK && row == RW'(NUM_BUF - 2))
            state_d = STREAM;
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            state     <= FILL;
            wr_en     <= '0;
            rd_en     <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            old_sel   <= SEL_W'(1 % NUM_BUF);
            row_end   <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            state     <= state_d;
            wr_en     <= data_valid ? sel_oh : '0;
            rd_en     <= (data_valid && !sof && state == STREAM) ? ~sel_oh : '0;
            row_end   <= col_wrap;
            frame_end <= row_wrap;
            if (data_valid) begin
                wr_addr <= sof ? '0 : ADDR_W'(col);
                rd_addr <= sof ? '0 : ADDR_W'(col);
            end
            if (col_wrap)
                old_sel <= sel_wrap ? '0 : wr_sel + 1'b1;
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: directed scenarios plus random traffic, checked against
// a pixel-index model for an 8x4 three-buffer instance and a 2x3 two-buffer instance.
module tb_line_buf_ctrl;

    logic clk, aclr_n;
    logic dv0, sof0, dv1, sof1;

    logic [2:0] a_we, a_re, a_wa, a_ra;
    logic [1:0] a_ws, a_os;
    logic       a_rv, a_rend, a_fend;

    logic [1:0] b_we, b_re;
    logic [0:0] b_wa, b_ra, b_ws, b_os;
    logic       b_rv, b_rend, b_fend;

    int tests = 0;
    int fails = 0;

    // Model state: pixels into current frame, lines completed since reset, last address.
    int m_p[2];
    int m_lt[2];
    int m_addr[2];

    line_buf_ctrl #(.LINE_W(8), .ADDR_W(3), .NUM_BUF(3), .ROWS(4)) dut (
        .clk(clk), .aclr_n(aclr_n), .data_valid(dv0), .sof(sof0),
        .wr_en(a_we), .wr_addr(a_wa), .rd_en(a_re), .rd_addr(a_ra),
        .wr_sel(a_ws), .old_sel(a_os), .rd_valid(a_rv),
        .row_end(a_rend), .frame_end(a_fend)
    );

    line_buf_ctrl #(.LINE_W(2), .ADDR_W(1), .NUM_BUF(2), .ROWS(3)) dut2 (
        .clk(clk), .aclr_n(aclr_n), .data_valid(dv1), .sof(sof1),
        .wr_en(b_we), .wr_addr(b_wa), .rd_en(b_re), .rd_addr(b_ra),
        .wr_sel(b_ws), .old_sel(b_os), .rd_valid(b_rv),
        .row_end(b_rend), .frame_end(b_fend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int id, input int we, input int re, input int rend,
                             input int fend);
        int nb, ws, os, rv, ln;
        nb = id ? 2 : 3;
        ln = id ? 2 : 8;
        ws = m_lt[id] % nb;
        os = (m_lt[id] == 0) ? (1 % nb) : (m_lt[id] % nb);
        rv = ((m_p[id] / ln) >= nb - 1) ? 1 : 0;
        if (id == 0) begin
            chk("wr_en",     32'(a_we),   32'(we));
            chk("rd_en",     32'(a_re),   32'(re));
            chk("wr_addr",   32'(a_wa),   32'(m_addr[0]));
            chk("rd_addr",   32'(a_ra),   32'(m_addr[0]));
            chk("wr_sel",    32'(a_ws),   32'(ws));
            chk("old_sel",   32'(a_os),   32'(os));
            chk("rd_valid",  32'(a_rv),   32'(rv));
            chk("row_end",   32'(a_rend), 32'(rend));
            chk("frame_end", 32'(a_fend), 32'(fend));
        end else begin
            chk("wr_en2",     32'(b_we),   32'(we));
            chk("rd_en2",     32'(b_re),   32'(re));
            chk("wr_addr2",   32'(b_wa),   32'(m_addr[1]));
            chk("rd_addr2",   32'(b_ra),   32'(m_addr[1]));
            chk("wr_sel2",    32'(b_ws),   32'(ws));
            chk("old_sel2",   32'(b_os),   32'(os));
            chk("rd_valid2",  32'(b_rv),   32'(rv));
            chk("row_end2",   32'(b_rend), 32'(rend));
            chk("frame_end2", 32'(b_fend), 32'(fend));
        end
    endtask

    task automatic do_reset(input bit dv);
        aclr_n = 1'b0; dv0 = dv; dv1 = dv; sof0 = 1'b0; sof1 = 1'b0;
        @(posedge clk); #1;
        aclr_n = 1'b1; dv0 = 1'b0; dv1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_p[i] = 0; m_lt[i] = 0; m_addr[i] = 0;
        end
        check_all(0, 0, 0, 0, 0);
        check_all(1, 0, 0, 0, 0);
    endtask

    // One clock on instance id with the given strobes, then compare against the model.
    task automatic step(input int id, input bit dv, input bit s);
        int ln, nb, rows, col, lif, we, re, rend, fend;
        ln   = id ? 2 : 8;
        nb   = id ? 2 : 3;
        rows = id ? 3 : 4;
        if (id == 0) begin dv0 = dv; sof0 = s; dv1 = 0; sof1 = 0; end
        else         begin dv1 = dv; sof1 = s; dv0 = 0; sof0 = 0; end
        @(posedge clk); #1;
        we = 0; re = 0; rend = 0; fend = 0;
        if (s) m_p[id] = 0;
        if (dv) begin
            col  = m_p[id] % ln;
            lif  = m_p[id] / ln;
            we   = 1 << (m_lt[id] % nb);
            re   = (lif >= nb - 1) ? (((1 << nb) - 1) & ~we) : 0;
            rend = (col == ln - 1) ? 1 : 0;
            fend = (rend == 1 && lif == rows - 1) ? 1 : 0;
            m_addr[id] = col;
            m_p[id]++;
            if (rend == 1) m_lt[id]++;
            if (fend == 1) m_p[id] = 0;
        end
        check_all(id, we, re, rend, fend);
    endtask

    initial begin
        aclr_n = 1'b0; dv0 = 0; sof0 = 0; dv1 = 0; sof1 = 0;
        do_reset(1'b0);

        // First line into buffer 0, then two more lines reaching STREAM.
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0);
        chk("l1_wr_sel", 32'(a_ws), 32'd1);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0);
        chk("l3_old_sel", 32'(a_os), 32'd0);

        // Gapped traffic across a frame boundary.
        for (int i = 0; i < 64; i++) step(0, (i % 2) == 0, 1'b0);

        // sof with a pixel at col 5 of row 2 while streaming.
        do_reset(1'b0);
        for (int i = 0; i < 21; i++) step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        chk("sof_wr_sel", 32'(a_ws), 32'd2);
        chk("sof_addr",   32'(a_wa), 32'd0);
        chk("sof_rv",     32'(a_rv), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b0);

        // Reset mid-line with a pixel present, then restart at buffer 0.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0);
        do_reset(1'b1);
        step(0, 1'b1, 1'b0);
        chk("rst_we", 32'(a_we), 32'd1);

        for (int i = 0; i < 300; i++)
            step(0, $urandom_range(3) != 0, $urandom_range(39) == 0);

        // Two-buffer instance.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) step(1, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++)
            step(1, $urandom_range(3) != 0, $urandom_range(29) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter LINE_W, default 1280: pixels per line; legal range 2..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 11: line-RAM address width.
REQ-003 Parameter NUM_BUF, default 3: number of line RAMs in rotation; legal range 2..8.
REQ-004 Parameter ROWS, default 1024: lines per frame; legal range 2..65535.
REQ-005 Derived constant SEL_W = max(1, clog2(NUM_BUF)).
REQ-006 Ports: clk input 1 system clock; aclr_n input 1 reset (one clock; reset is synchronous and active-low).
REQ-007 Ports: data_valid input 1 pixel strobe; sof input 1 start-of-frame resync.
REQ-008 Ports: wr_en output NUM_BUF one-hot write enable; wr_addr output ADDR_W write address.
REQ-009 Ports: rd_en output NUM_BUF read enables; rd_addr output ADDR_W read address.
REQ-010 Ports: wr_sel output SEL_W buffer being written; old_sel output SEL_W oldest stored line.
REQ-011 Ports: rd_valid output 1 all read lines hold data of the current frame; row_end output 1 pulse; frame_end output 1 pulse.

Function
REQ-012 All outputs SHALL be registered; wr_en, wr_addr, rd_en, rd_addr, row_end and frame_end SHALL appear exactly 1 cycle after the accepting data_valid.
REQ-013 Column counter col (0..LINE_W-1) SHALL advance only on data_valid and SHALL wrap LINE_W-1 -> 0; wr_addr = rd_addr = col of the accepted pixel.
REQ-014 wr_en SHALL be one-hot at bit wr_sel when the pixel is accepted, and all-zero otherwise.
REQ-015 rd_en SHALL assert every bit except wr_sel when the pixel is accepted and state is STREAM, and SHALL be all-zero otherwise.
REQ-016 On the pixel with col = LINE_W-1: row_end SHALL pulse; wr_sel SHALL advance (NUM_BUF-1 -> 0); old_sel SHALL become the previous wr_sel+1 mod NUM_BUF; row counter SHALL increment.
REQ-017 On the pixel with col = LINE_W-1 and row = ROWS-1: row_end and frame_end SHALL pulse together; row SHALL return to 0; fill count SHALL clear; state SHALL return to FILL.
REQ-018 FSM states: FILL and STREAM.
REQ-019 FILL -> STREAM when the fill count reaches NUM_BUF-1 completed lines; rd_valid = (state == STREAM).
REQ-020 STREAM -> FILL on frame end or sof.
REQ-021 sof SHALL force col, row and fill count to 0 and state to FILL; wr_sel and old_sel SHALL be kept; any partial line SHALL be discarded without a row_end.
REQ-022 If sof and data_valid occur in the same cycle, the pixel SHALL be accepted as col 0, row 0 of the new frame (wr_en asserted, rd_en zero).
REQ-023 Counters SHALL saturate-free wrap using exact widths clog2(LINE_W), clog2(ROWS) and clog2(NUM_BUF); no compare SHALL use out-of-range values.
REQ-024 With NUM_BUF=2, STREAM SHALL be entered after 1 line and a single rd_en bit SHALL be active.

Reset
REQ-025 While aclr_n=0 at a clk edge: wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, wr_sel=0, old_sel=1 mod NUM_BUF, row_end=0, frame_end=0, rd_valid=0, state=FILL, all counters 0.
REQ-026 Reset asserted mid-line SHALL abort the line with no pulses; the first pixel after release SHALL be col 0 written to buffer 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the clog2 function and the default parameter constants.
REQ-028 One sub-module, lb_wrap_counter (parameterised modulus, enable, sync clear, wrap flag), SHALL be used for the col, row and buffer-select counters.

Verification (LINE_W=8, NUM_BUF=3, ROWS=4)
REQ-029 Reset release, then 8 continuous data_valid -> wr_en=3'b001 with addr 0..7, row_end on the 8th output cycle, wr_sel=1, rd_en=0.
REQ-030 16 further pixels -> after the 2nd line rd_valid=1; 3rd line gives wr_en=3'b100, rd_en=3'b011, old_sel=0.
REQ-031 32 pixels with data_valid toggling every other cycle -> addresses contiguous, no gaps or duplicates, frame_end coincident with the 4th row_end.
REQ-032 sof asserted at col 5 of row 2 together with data_valid -> that pixel written at addr 0, rd_valid=0, no row_end, wr_sel unchanged.
REQ-033 aclr_n low for 1 cycle at col 3 -> all outputs reach their reset values, next pixel goes to buffer 0 addr 0.
REQ-034 NUM_BUF=2, LINE_W=2 -> rd_valid after 2 pixels, rd_en alternates 2'b10/2'b01 per line.
